decoder_strobe: RTL and testbench

//  Sequential 3-to-8 (generally SEL_W-to-2**SEL_W) decoder. It is the

---
 rtl/decoder_strobe.sv | 158 +++++++++++++++
 tb/tb_decoder_strobe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_strobe.sv
// Sequential SEL_W-to-2**SEL_W decoder: codes are queued in a small FIFO and
// replayed in order as registered one-hot strobes of HOLD cycles followed by GAP idle cycles.
module decoder_strobe #(
  parameter int SEL_W = 3,
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      code,
  output logic [2**SEL_W-1:0]   out_onehot,
  output logic                  out_valid,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int OUT_W   = 2**SEL_W;
  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  // Handshake: a code transfers on a rising edge where in_valid && in_ready;
  // the source keeps code stable while in_valid is high and in_ready is low.

  logic [SEL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [SEL_W-1:0] head;
  logic [OUT_W-1:0] head_onehot;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [OUT_W-1:0] onehot_q;
  logic [OUT_W-1:0] onehot_n;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign in_ready    = !full && enable && !reset;
  assign push        = in_valid && in_ready;
  assign head        = mem[rd_ptr];
  assign head_onehot = OUT_W'(1) << head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // With enable low nothing advances, so the remaining hold/gap count resumes later.
  always_comb begin
    pop      = 1'b0;
    state_n  = state;
    cnt_n    = cnt;
    onehot_n = onehot_q;
    if (enable) begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            onehot_n = head_onehot;
            cnt_n    = HOLD_LD;
            state_n  = S_STROBE;
          end
        end
        S_STROBE: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (GAP > 0) begin
            onehot_n = '0;
            cnt_n    = GAP_LD;
            state_n  = S_GAP;
          end else if (!empty) begin
            pop      = 1'b1;
            onehot_n = head_onehot;
            cnt_n    = HOLD_LD;
          end else begin
            onehot_n = '0;
            state_n  = S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (!empty) begin
            pop      = 1'b1;
            onehot_n = head_onehot;
            cnt_n    = HOLD_LD;
            state_n  = S_STROBE;
          end else begin
            state_n = S_IDLE;
          end
        end
        default: begin
          onehot_n = '0;
          cnt_n    = '0;
          state_n  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      onehot_q <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      onehot_q <= onehot_n;
    end
  end

  assign out_onehot = enable ? onehot_q : '0;
  assign out_valid  = |out_onehot;
  assign busy       = (state != S_IDLE) || !empty;
  assign state_dbg  = state;

endmodule

// File: tb/tb_decoder_strobe.sv
// Bench for decoder_strobe: timeline-based reference model with a per-cycle
// compare process, directed scenarios with literal expectations, and random traffic.
module tb_decoder_strobe;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, enable, in_valid, in_ready, out_valid, busy;
  logic [SEL_W-1:0] code;
  logic [OUT_W-1:0] out_onehot;
  logic [1:0]       state_dbg;

  logic             g_reset, g_enable, g_in_valid, g_in_ready, g_out_valid, g_busy;
  logic [SEL_W-1:0] g_code;
  logic [OUT_W-1:0] g_out;
  logic [1:0]       g_state;

  decoder_strobe #(.SEL_W(SEL_W), .HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .code(code), .out_onehot(out_onehot),
    .out_valid(out_valid), .busy(busy), .state_dbg(state_dbg)
  );

  decoder_strobe #(.SEL_W(SEL_W), .HOLD(HOLD), .GAP(0), .DEPTH(DEPTH)) dut_g0 (
    .clk(clk), .reset(g_reset), .enable(g_enable), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .code(g_code), .out_onehot(g_out),
    .out_valid(g_out_valid), .busy(g_busy), .state_dbg(g_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queued codes plus a timeline of display values still to come
  logic [SEL_W-1:0] exp_q[$];
  logic [OUT_W-1:0] tl_q[$];
  logic [OUT_W-1:0] m_disp;
  bit               m_active;
  bit               m_acc;
  bit               model_on = 0;

  always @(posedge clk) begin
    logic [SEL_W-1:0] c;
    bit rdy;
    rdy   = (exp_q.size() < DEPTH) && enable && !reset;
    m_acc = in_valid && rdy;
    if (reset) begin
      exp_q.delete();
      tl_q.delete();
      m_disp   = '0;
      m_active = 0;
      model_on = 1;
    end else if (enable) begin
      if (tl_q.size() > 0) begin
        m_disp   = tl_q.pop_front();
        m_active = 1;
      end else if (exp_q.size() > 0) begin
        c        = exp_q.pop_front();
        m_disp   = OUT_W'(1) << c;
        m_active = 1;
        for (int i = 0; i < HOLD - 1; i++) tl_q.push_back(m_disp);
        for (int i = 0; i < GAP; i++) tl_q.push_back('0);
      end else begin
        m_disp   = '0;
        m_active = 0;
      end
      if (m_acc) exp_q.push_back(code);
    end
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    logic [OUT_W-1:0] e_out;
    if (model_on) begin
      e_out = enable ? m_disp : '0;
      chk("out_onehot", out_onehot, e_out);
      chk("out_valid", out_valid, e_out != '0);
      chk("in_ready", in_ready, (exp_q.size() < DEPTH) && enable && !reset);
      chk("busy", busy, m_active || (exp_q.size() > 0));
      chk("state_active", state_dbg != 2'd0, m_active);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [OUT_W-1:0] trace[$];
  logic [SEL_W-1:0] t6_list [6];
  int start, pushed, idx, n80, runs80;
  bit saw_low, saw7_blocked;
  logic [OUT_W-1:0] e8;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; enable = 1; in_valid = 0; code = '0;
    g_reset = 1; g_enable = 1; g_in_valid = 0; g_code = '0;
    settle(3);
    @(negedge clk);
    chk("rst_out", out_onehot, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_g0_busy", g_busy, 1'b0);

    // test 1: single code 3
    step();
    reset = 0; g_reset = 0; in_valid = 1; code = 3'd3;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      e8 = (k >= 2 && k <= 5) ? 8'h08 : 8'h00;
      chk($sformatf("t1_out_c%0d", k), out_onehot, e8);
      chk($sformatf("t1_valid_c%0d", k), out_valid, e8 != 0);
      chk($sformatf("t1_busy_c%0d", k), busy, (k >= 1 && k <= 6));
      step();
      in_valid = 0;
    end
    settle(3);

    // test 2: push 0..7 with in_valid held
    in_valid = 1; code = 3'd0; saw_low = 0; pushed = 0; trace.delete();
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      trace.push_back(out_onehot);
      if (in_valid && !in_ready) saw_low = 1;
      step();
      if (in_valid && m_acc) begin
        pushed++;
        if (code == 3'd7) in_valid = 0;
        else code = code + 3'd1;
      end
    end
    chk("t2_pushed", pushed, 8);
    chk("t2_ready_dropped", saw_low, 1'b1);
    start = -1;
    for (int i = 0; i < trace.size(); i++) if (trace[i] != 0 && start < 0) start = i;
    if (start < 0) chk("t2_start_found", 0, 1);
    else begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 5; j++) begin
          if (!(i == 7 && j == 4)) begin
            e8 = (j < 4) ? (OUT_W'(1) << i) : 8'h00;
            chk($sformatf("t2_s%0d_c%0d", i, j), trace[start + 5*i + j], e8);
          end
        end
      end
      n80 = 0;
      for (int i = start + 40; i < trace.size(); i++) if (trace[i] != 0) n80++;
      chk("t2_no_extra", n80, 0);
    end
    settle(3);

    // test 3: enable low for 3 cycles after two cycles of 8'h20
    in_valid = 1; code = 3'd5;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e8 = (k == 2 || k == 3 || k == 7 || k == 8) ? 8'h20 : 8'h00;
      chk($sformatf("t3_out_c%0d", k), out_onehot, e8);
      if (k >= 4 && k <= 6) chk($sformatf("t3_ready_c%0d", k), in_ready, 1'b0);
      if (k == 3) chk("t3_ready_c3", in_ready, 1'b1);
      step();
      in_valid = 0;
      enable = !((k + 1) >= 4 && (k + 1) <= 6);
    end
    settle(3);

    // test 4: reset pulse during strobe of code 6 with two codes queued
    in_valid = 1; code = 3'd6;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 2 || k == 3) chk($sformatf("t4_out_c%0d", k), out_onehot, 8'h40);
      if (k >= 4) begin
        chk($sformatf("t4_out_c%0d", k), out_onehot, 8'h00);
        chk($sformatf("t4_busy_c%0d", k), busy, 1'b0);
      end
      step();
      in_valid = (k + 1) <= 2;
      code     = ((k + 1) == 1) ? 3'd1 : 3'd2;
      reset    = ((k + 1) == 3);
    end
    settle(3);

    // test 5: GAP=0 build, back-to-back strobes
    g_in_valid = 1; g_code = 3'd5;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e8 = (k >= 2 && k <= 5) ? 8'h20 : (k >= 6 && k <= 9) ? 8'h40 : 8'h00;
      chk($sformatf("t5_out_c%0d", k), g_out, e8);
      chk($sformatf("t5_valid_c%0d", k), g_out_valid, e8 != 0);
      if (k == 5 || k >= 10) chk($sformatf("t5_busy_c%0d", k), g_busy, k == 5);
      step();
      g_in_valid = (k + 1) == 1;
      g_code     = 3'd6;
    end
    settle(3);

    // test 6: code 7 presented while the FIFO is full
    t6_list[0] = 3'd1; t6_list[1] = 3'd2; t6_list[2] = 3'd3;
    t6_list[3] = 3'd4; t6_list[4] = 3'd5; t6_list[5] = 3'd7;
    idx = 0; saw7_blocked = 0; trace.delete();
    in_valid = 1; code = t6_list[0];
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      trace.push_back(out_onehot);
      if (in_valid && code == 3'd7 && !in_ready) saw7_blocked = 1;
      step();
      if (in_valid && m_acc) begin
        idx++;
        if (idx == 6) in_valid = 0;
        else code = t6_list[idx];
      end
    end
    chk("t6_all_accepted", idx, 6);
    chk("t6_blocked_when_full", saw7_blocked, 1'b1);
    n80 = 0; runs80 = 0;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i] == 8'h80) begin
        n80++;
        if (i == 0 || trace[i-1] != 8'h80) runs80++;
      end
    end
    chk("t6_80_cycles", n80, HOLD);
    chk("t6_80_runs", runs80, 1);
    settle(3);

    // random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      if (!(in_valid && !m_acc)) begin
        in_valid = ($urandom_range(0, 99) < 60);
        code     = SEL_W'($urandom_range(0, 7));
      end
      enable = ($urandom_range(0, 99) < 85);
      reset  = ($urandom_range(0, 999) < 5);
      step();
    end
    in_valid = 0; enable = 1; reset = 0;
    settle(60);
    @(negedge clk);
    chk("final_idle_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
